// File: rtl/spu_sequencer_if.sv
// Sprite command stream between a command producer and the SPU sequencer.
// A command transfers on a rising clock edge where valid and ready are both high.
interface spu_sequencer_if;
  logic        valid;
  logic        ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [31:0] color;  // RGBA, alpha already applied
  logic        last;

  modport master (output valid, x, y, color, last, input ready);
  modport slave  (input valid, x, y, color, last, output ready);
endinterface

// File: rtl/spu_sequencer.sv
// Tile sequencer for the sprite processing unit: clears a tile, draws each sprite
// over it, then reads the tile back out as a stream of pixels.
module spu_sequencer #(
  parameter  int TILE_SIZE = 10,
  localparam int CW        = $clog2(TILE_SIZE)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [9:0]    i_tile_x,
  input  logic [9:0]    i_tile_y,
  input  logic [23:0]   i_clear_color,
  spu_sequencer_if.slave sprite,
  output logic          o_spu_enable,
  output logic          o_clear,
  output logic          o_draw_sprite,
  output logic          o_get_color,
  output logic [9:0]    o_tile_x,
  output logic [9:0]    o_tile_y,
  output logic [CW-1:0] o_process_x,
  output logic [CW-1:0] o_process_y,
  output logic [23:0]   o_clear_color,
  output logic [15:0]   o_sprite_x,
  output logic [15:0]   o_sprite_y,
  output logic [31:0]   o_sprite_color,
  input  logic [23:0]   i_spu_color,
  output logic          o_pixel_valid,
  output logic [CW-1:0] o_pixel_x,
  output logic [CW-1:0] o_pixel_y,
  output logic [23:0]   o_pixel_color,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [CW-1:0] LAST = CW'(TILE_SIZE - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_SPRITE, DRAW, READ, FLUSH} state_t;

  typedef struct packed {
    logic spu_enable;
    logic clear;
    logic draw_sprite;
    logic get_color;
    logic sprite_ready;
    logic busy;
    logic done;
  } ctl_t;

  // Control strobes as a pure function of the state they belong to.
  function automatic ctl_t ctl_for(state_t s);
    ctl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      CLEAR:       begin c.spu_enable = 1'b1; c.clear       = 1'b1; end
      DRAW:        begin c.spu_enable = 1'b1; c.draw_sprite = 1'b1; end
      READ:        begin c.spu_enable = 1'b1; c.get_color   = 1'b1; end
      WAIT_SPRITE: c.sprite_ready = 1'b1;
      FLUSH:       c.done         = 1'b1;
      default:     ;
    endcase
    return c;
  endfunction

  state_t          state;
  ctl_t            ctl;
  logic [CW-1:0]   px;
  logic [CW-1:0]   py;
  logic            sprite_last;
  logic            sweep_end;
  logic            sweeping;

  assign sweep_end = (px == LAST) && (py == LAST);
  assign sweeping  = (state == CLEAR) || (state == DRAW) || (state == READ);

  // NOTE: every register of the FSM is assigned with <= so all of them see the
  // pre-edge values of each other; mixing in = here would create order-dependent logic.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      ctl            <= '0;
      px             <= '0;
      py             <= '0;
      o_tile_x       <= '0;
      o_tile_y       <= '0;
      o_clear_color  <= '0;
      o_sprite_x     <= '0;
      o_sprite_y     <= '0;
      o_sprite_color <= '0;
      sprite_last    <= 1'b0;
    end else begin
      // x-fastest sweep that wraps back to (0,0) after the last pixel
      if (sweeping) begin
        if (px == LAST) begin
          px <= '0;
          py <= (py == LAST) ? '0 : py + 1'b1;
        end else begin
          px <= px + 1'b1;
        end
      end

      // NOTE: the strobes are registered together with the state by loading the
      // decode of the next state, so they are glitch-free and aligned with it.
      case (state)
        IDLE: if (i_start) begin
          o_tile_x      <= i_tile_x;
          o_tile_y      <= i_tile_y;
          o_clear_color <= i_clear_color;
          px            <= '0;
          py            <= '0;
          state         <= CLEAR;
          ctl           <= ctl_for(CLEAR);
        end
        CLEAR: if (sweep_end) begin
          state <= WAIT_SPRITE;
          ctl   <= ctl_for(WAIT_SPRITE);
        end
        WAIT_SPRITE: if (sprite.valid && ctl.sprite_ready) begin
          o_sprite_x     <= sprite.x;
          o_sprite_y     <= sprite.y;
          o_sprite_color <= sprite.color;
          sprite_last    <= sprite.last;
          state          <= DRAW;
          ctl            <= ctl_for(DRAW);
        end
        DRAW: if (sweep_end) begin
          state <= sprite_last ? READ : WAIT_SPRITE;
          ctl   <= ctl_for(sprite_last ? READ : WAIT_SPRITE);
        end
        READ: if (sweep_end) begin
          state <= FLUSH;
          ctl   <= ctl_for(FLUSH);
        end
        FLUSH: begin
          state <= IDLE;
          ctl   <= ctl_for(IDLE);
        end
        default: begin
          state <= IDLE;
          ctl   <= ctl_for(IDLE);
        end
      endcase
    end
  end

  // Readout lags the sweep by one cycle to match the SPU's colour latency.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_pixel_valid <= 1'b0;
      o_pixel_x     <= '0;
      o_pixel_y     <= '0;
    end else begin
      o_pixel_valid <= ctl.get_color;
      o_pixel_x     <= px;
      o_pixel_y     <= py;
    end
  end

  assign o_pixel_color = o_pixel_valid ? i_spu_color : '0;

  assign o_spu_enable  = ctl.spu_enable;
  assign o_clear       = ctl.clear;
  assign o_draw_sprite = ctl.draw_sprite;
  assign o_get_color   = ctl.get_color;
  assign sprite.ready  = ctl.sprite_ready;
  assign o_busy        = ctl.busy;
  assign o_done        = ctl.done;
  assign o_process_x   = px;
  assign o_process_y   = py;

endmodule

// File: tb/tb_spu_sequencer.sv
// Self-checking bench for spu_sequencer: SPU frame-buffer model, pixel scoreboard
// and per-scenario tasks covering timing, latching, start/reset corner cases.
module tb_spu_sequencer;
  localparam int TS   = 10;
  localparam int CW   = $clog2(TS);
  localparam int NPIX = TS * TS;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [9:0]    i_tile_x, i_tile_y;
  logic [23:0]   i_clear_color;
  logic          o_spu_enable, o_clear, o_draw_sprite, o_get_color;
  logic [9:0]    o_tile_x, o_tile_y;
  logic [CW-1:0] o_process_x, o_process_y;
  logic [23:0]   o_clear_color;
  logic [15:0]   o_sprite_x, o_sprite_y;
  logic [31:0]   o_sprite_color;
  logic [23:0]   i_spu_color;
  logic          o_pixel_valid;
  logic [CW-1:0] o_pixel_x, o_pixel_y;
  logic [23:0]   o_pixel_color;
  logic          o_busy, o_done;

  spu_sequencer_if sprite_bus ();

  spu_sequencer #(.TILE_SIZE(TS)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_tile_x       (i_tile_x),
    .i_tile_y       (i_tile_y),
    .i_clear_color  (i_clear_color),
    .sprite         (sprite_bus),
    .o_spu_enable   (o_spu_enable),
    .o_clear        (o_clear),
    .o_draw_sprite  (o_draw_sprite),
    .o_get_color    (o_get_color),
    .o_tile_x       (o_tile_x),
    .o_tile_y       (o_tile_y),
    .o_process_x    (o_process_x),
    .o_process_y    (o_process_y),
    .o_clear_color  (o_clear_color),
    .o_sprite_x     (o_sprite_x),
    .o_sprite_y     (o_sprite_y),
    .o_sprite_color (o_sprite_color),
    .i_spu_color    (i_spu_color),
    .o_pixel_valid  (o_pixel_valid),
    .o_pixel_x      (o_pixel_x),
    .o_pixel_y      (o_pixel_y),
    .o_pixel_color  (o_pixel_color),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 i_clock = ~i_clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] c;
  } pix_t;
  pix_t sb[$];

  // Sprite commands for the current tile
  int          spr_n;
  logic [15:0] spr_x[4];
  logic [15:0] spr_y[4];
  logic [31:0] spr_c[4];
  int          spr_dly[4];

  // SPU model: a sprite covers pixels at or right/below its tile-local origin
  logic [23:0] fb[TS][TS];
  always @(posedge i_clock) begin
    if (o_clear) fb[o_process_y][o_process_x] <= o_clear_color;
    if (o_draw_sprite && o_process_x >= o_sprite_x && o_process_y >= o_sprite_y)
      fb[o_process_y][o_process_x] <= o_sprite_color[31:8];
    if (o_get_color) i_spu_color <= fb[o_process_y][o_process_x];
  end

  function automatic logic [23:0] exp_color(int px, int py, logic [23:0] clr);
    logic [23:0] c;
    c = clr;
    for (int i = 0; i < spr_n; i++)
      if (px >= int'(spr_x[i]) && py >= int'(spr_y[i])) c = spr_c[i][31:8];
    return c;
  endfunction

  // Per-tile activity monitor
  int cnt_clear, cnt_draw, cnt_get, cnt_ready, cnt_done, hs_cnt, viol;
  int since_start, done_lat, draw_at_get, draw_since_hs;
  int first_x, first_y;
  bit first_clear, get_seen, hs_seen;

  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (i_start && !o_busy) since_start = 0;
      else since_start++;
      if (since_start == 1) begin
        first_x     = int'(o_process_x);
        first_y     = int'(o_process_y);
        first_clear = o_clear;
      end
      if (o_clear) cnt_clear++;
      if (o_draw_sprite) begin cnt_draw++; draw_since_hs++; end
      if (o_get_color) begin
        if (!get_seen) draw_at_get = cnt_draw;
        get_seen = 1'b1;
        cnt_get++;
      end
      if (sprite_bus.ready) cnt_ready++;
      if ((int'(o_clear) + int'(o_draw_sprite) + int'(o_get_color)) > 1 ||
          (!o_spu_enable && (o_clear || o_draw_sprite || o_get_color)))
        viol++;
      if (sprite_bus.valid && sprite_bus.ready) begin
        if (hs_seen && draw_since_hs != NPIX) viol++;
        hs_seen       = 1'b1;
        draw_since_hs = 0;
        hs_cnt++;
      end
      if (o_pixel_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pixel_unexpected: got (%0d,%0d) %06h, required no pixel",
                   o_pixel_x, o_pixel_y, o_pixel_color);
        end else begin
          pix_t e;
          e = sb.pop_front();
          if (int'(o_pixel_x) != e.x || int'(o_pixel_y) != e.y || o_pixel_color !== e.c) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d) %06h, required (%0d,%0d) %06h",
                     o_pixel_x, o_pixel_y, o_pixel_color, e.x, e.y, e.c);
          end
        end
      end
      if (o_done) begin
        cnt_done++;
        done_lat = since_start;
        checks++;
        if (!o_pixel_valid) begin
          errors++;
          $display("FAIL done_last_pixel: got pixel_valid=0 with o_done, required 1");
        end
      end
    end
  end

  task automatic tile_begin();
    cnt_clear = 0; cnt_draw = 0; cnt_get = 0; cnt_ready = 0; cnt_done = 0;
    hs_cnt = 0; viol = 0; draw_at_get = -1; draw_since_hs = 0;
    get_seen = 1'b0; hs_seen = 1'b0; first_x = -1; first_y = -1; first_clear = 1'b0;
  endtask

  task automatic drive_sprite(int i);
    sprite_bus.valid = 1'b1;
    sprite_bus.x     = spr_x[i];
    sprite_bus.y     = spr_y[i];
    sprite_bus.color = spr_c[i];
    sprite_bus.last  = (i == spr_n - 1);
  endtask

  // Runs one tile end to end; exp_lat / exp_ready < 0 skip those checks.
  task automatic run_tile(input logic [9:0] tx, input logic [9:0] ty, input logic [23:0] clr,
                          input bit rnd, input bit hold_start, input int exp_lat,
                          input int exp_ready);
    int n;
    tile_begin();
    for (int y = 0; y < TS; y++)
      for (int x = 0; x < TS; x++)
        sb.push_back('{x, y, exp_color(x, y, clr)});

    @(posedge i_clock); #1;
    i_start       = 1'b1;
    i_tile_x      = tx;
    i_tile_y      = ty;
    i_clear_color = clr;
    if (!rnd && spr_dly[0] == 0) drive_sprite(0);
    @(posedge i_clock); #1;
    if (!hold_start) i_start = 1'b0;
    i_tile_x      = 10'($urandom);
    i_tile_y      = 10'($urandom);
    i_clear_color = 24'($urandom);

    if (rnd) begin
      int idx;
      idx = 0;
      n   = 0;
      while (idx < spr_n && n < 5000) begin
        drive_sprite(idx);
        sprite_bus.valid = 1'($urandom);
        @(negedge i_clock);
        if (sprite_bus.valid && sprite_bus.ready) idx++;
        @(posedge i_clock); #1;
        n++;
      end
      sprite_bus.valid = 1'b0;
    end else begin
      for (int i = 0; i < spr_n; i++) begin
        if (spr_dly[i] != 0) begin
          n = 0;
          do begin @(negedge i_clock); n++; end while (!sprite_bus.ready && n < 1000);
          repeat (spr_dly[i]) @(posedge i_clock);
          #1;
        end
        drive_sprite(i);
        n = 0;
        do begin @(negedge i_clock); n++; end
        while (!(sprite_bus.valid && sprite_bus.ready) && n < 1000);
        checks++;
        if (!(sprite_bus.valid && sprite_bus.ready)) begin
          errors++;
          $display("FAIL sprite_handshake_timeout: sprite %0d not accepted within %0d cycles", i, n);
        end
        @(posedge i_clock); #1;
        sprite_bus.valid = 1'b0;
      end
    end

    n = 0;
    do begin @(negedge i_clock); n++; end while (!o_done && n < 2000);
    i_start = 1'b0;
    checks++;
    if (!o_done) begin
      errors++;
      $display("FAIL done_timeout: no o_done within %0d cycles", n);
    end
    repeat (5) @(negedge i_clock);

    checks++;
    if (exp_lat >= 0 && done_lat != exp_lat) begin
      errors++; $display("FAIL done_latency: got %0d, required %0d", done_lat, exp_lat);
    end
    checks++;
    if (cnt_done != 1) begin
      errors++; $display("FAIL done_count: got %0d, required 1", cnt_done);
    end
    checks++;
    if (cnt_clear != NPIX || cnt_draw != NPIX * spr_n || cnt_get != NPIX) begin
      errors++;
      $display("FAIL sweep_counts: got clear=%0d draw=%0d get=%0d, required %0d/%0d/%0d",
               cnt_clear, cnt_draw, cnt_get, NPIX, NPIX * spr_n, NPIX);
    end
    checks++;
    if (draw_at_get != NPIX * spr_n) begin
      errors++; $display("FAIL read_after_last: got %0d draws before read, required %0d",
                         draw_at_get, NPIX * spr_n);
    end
    checks++;
    if (exp_ready >= 0 && cnt_ready != exp_ready) begin
      errors++; $display("FAIL ready_cycles: got %0d, required %0d", cnt_ready, exp_ready);
    end
    checks++;
    if (hs_cnt != spr_n || viol != 0) begin
      errors++; $display("FAIL handshake_excl: got hs=%0d viol=%0d, required hs=%0d viol=0",
                         hs_cnt, viol, spr_n);
    end
    checks++;
    if (first_x != 0 || first_y != 0 || first_clear != 1'b1) begin
      errors++; $display("FAIL first_clear_pixel: got (%0d,%0d) clear=%0b, required (0,0) clear=1",
                         first_x, first_y, first_clear);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL pixel_missing: got %0d pixels outstanding, required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (o_busy !== 1'b0 || o_tile_x !== tx || o_tile_y !== ty || o_clear_color !== clr) begin
      errors++; $display("FAIL tile_latch_idle: got busy=%0b tile=(%0d,%0d) clr=%06h, required 0 (%0d,%0d) %06h",
                         o_busy, o_tile_x, o_tile_y, o_clear_color, tx, ty, clr);
    end
    checks++;
    if (o_sprite_x !== spr_x[spr_n-1] || o_sprite_y !== spr_y[spr_n-1] ||
        o_sprite_color !== spr_c[spr_n-1]) begin
      errors++; $display("FAIL sprite_latch: got (%0d,%0d) %08h, required (%0d,%0d) %08h",
                         o_sprite_x, o_sprite_y, o_sprite_color,
                         spr_x[spr_n-1], spr_y[spr_n-1], spr_c[spr_n-1]);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    #1;
    checks++;
    if ({o_spu_enable, o_clear, o_draw_sprite, o_get_color, sprite_bus.ready,
         o_pixel_valid, o_busy, o_done} !== 8'h00) begin
      errors++; $display("FAIL reset_ctl: got %08b, required 00000000",
                         {o_spu_enable, o_clear, o_draw_sprite, o_get_color, sprite_bus.ready,
                          o_pixel_valid, o_busy, o_done});
    end
    checks++;
    if ({o_process_x, o_process_y, o_tile_x, o_tile_y, o_clear_color, o_sprite_x, o_sprite_y,
         o_sprite_color, o_pixel_x, o_pixel_y, o_pixel_color} !== '0) begin
      errors++; $display("FAIL reset_data: got nonzero, required all zero (tile=%0d,%0d cnt=%0d,%0d)",
                         o_tile_x, o_tile_y, o_process_x, o_process_y);
    end
    repeat (3) @(posedge i_clock);
    #1 i_reset = 1'b0;
  endtask

  task automatic test_single_sprite();
    spr_n = 1; spr_x[0] = 16'd5; spr_y[0] = 16'd4; spr_c[0] = 32'h00AB12FF; spr_dly[0] = 0;
    run_tile(10'd2, 10'd3, 24'h102030, 1'b0, 1'b0, 302, 1);
  endtask

  task automatic test_full_cover();
    spr_n = 1; spr_x[0] = 16'd0; spr_y[0] = 16'd0; spr_c[0] = 32'hFF0000FF; spr_dly[0] = 0;
    run_tile(10'd7, 10'd1, 24'h000000, 1'b0, 1'b0, 302, 1);
  endtask

  task automatic test_multi_sprite();
    spr_n = 3;
    spr_x[0] = 16'd2; spr_y[0] = 16'd2; spr_c[0] = 32'h11223380; spr_dly[0] = 4;
    spr_x[1] = 16'd6; spr_y[1] = 16'd0; spr_c[1] = 32'h44556680; spr_dly[1] = 4;
    spr_x[2] = 16'd0; spr_y[2] = 16'd8; spr_c[2] = 32'h778899FF; spr_dly[2] = 4;
    run_tile(10'd1023, 10'd512, 24'hABCDEF, 1'b0, 1'b0, 516, 15);
  endtask

  task automatic test_start_held();
    spr_n = 1; spr_x[0] = 16'd3; spr_y[0] = 16'd9; spr_c[0] = 32'h0F0F0FFF; spr_dly[0] = 0;
    run_tile(10'd4, 10'd5, 24'h556677, 1'b0, 1'b1, 302, 1);
  endtask

  task automatic test_reset_mid_draw();
    int n;
    tile_begin();
    spr_n = 1; spr_x[0] = 16'd1; spr_y[0] = 16'd1; spr_c[0] = 32'hCAFE00FF; spr_dly[0] = 0;
    @(posedge i_clock); #1;
    i_start = 1'b1; i_tile_x = 10'd9; i_tile_y = 10'd8; i_clear_color = 24'h123456;
    drive_sprite(0);
    @(posedge i_clock); #1;
    i_start = 1'b0;
    n = 0;
    do begin @(negedge i_clock); n++; end
    while (!(o_draw_sprite && o_process_x == 4 && o_process_y == 7) && n < 1000);
    sprite_bus.valid = 1'b0;
    checks++;
    if (!(o_draw_sprite && o_process_x == 4 && o_process_y == 7)) begin
      errors++; $display("FAIL reach_draw_4_7: got draw=%0b (%0d,%0d), required draw=1 (4,7)",
                         o_draw_sprite, o_process_x, o_process_y);
    end
    #1 i_reset = 1'b1;
    #1;
    checks++;
    if ({o_spu_enable, o_clear, o_draw_sprite, o_get_color, sprite_bus.ready,
         o_pixel_valid, o_busy, o_done} !== 8'h00) begin
      errors++; $display("FAIL async_reset_ctl: got %08b, required 00000000",
                         {o_spu_enable, o_clear, o_draw_sprite, o_get_color, sprite_bus.ready,
                          o_pixel_valid, o_busy, o_done});
    end
    checks++;
    if ({o_process_x, o_process_y, o_tile_x, o_tile_y, o_clear_color, o_sprite_x, o_sprite_y,
         o_sprite_color, o_pixel_x, o_pixel_y, o_pixel_color} !== '0) begin
      errors++; $display("FAIL async_reset_data: got cnt=(%0d,%0d) tile=(%0d,%0d) spr=%08h, required all zero",
                         o_process_x, o_process_y, o_tile_x, o_tile_y, o_sprite_color);
    end
    repeat (2) @(posedge i_clock);
    #1 i_reset = 1'b0;
    repeat (3) @(negedge i_clock);
    checks++;
    if (cnt_done != 0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL abandoned_tile: got done=%0d busy=%0b, required 0 0", cnt_done, o_busy);
    end
    run_tile(10'd6, 10'd6, 24'h0A0B0C, 1'b0, 1'b0, 302, 1);
  endtask

  task automatic test_random_valid();
    spr_n = 3;
    for (int i = 0; i < spr_n; i++) begin
      spr_x[i] = 16'($urandom_range(0, TS - 1));
      spr_y[i] = 16'($urandom_range(0, TS - 1));
      spr_c[i] = $urandom;
    end
    run_tile(10'($urandom), 10'($urandom), 24'($urandom), 1'b1, 1'b0, -1, -1);
  endtask

  task automatic test_back_to_back();
    spr_n = 2;
    spr_x[0] = 16'd0; spr_y[0] = 16'd5; spr_c[0] = 32'h13579BFF; spr_dly[0] = 0;
    spr_x[1] = 16'd5; spr_y[1] = 16'd0; spr_c[1] = 32'h2468ACFF; spr_dly[1] = 0;
    run_tile(10'd0, 10'd0, 24'hFFFFFF, 1'b0, 1'b0, 403, 2);
    run_tile(10'd1, 10'd2, 24'h000001, 1'b0, 1'b0, 403, 2);
  endtask

  initial begin
    i_start          = 1'b0;
    i_tile_x         = '0;
    i_tile_y         = '0;
    i_clear_color    = '0;
    sprite_bus.valid = 1'b0;
    sprite_bus.x     = '0;
    sprite_bus.y     = '0;
    sprite_bus.color = '0;
    sprite_bus.last  = 1'b0;
    since_start      = 0;
    done_lat         = -1;
    tile_begin();

    test_reset();
    test_single_sprite();
    test_full_cover();
    test_multi_sprite();
    test_start_held();
    test_reset_mid_draw();
    test_random_valid();
    test_random_valid();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
